// File: rtl/mmm_defs_pkg.sv
// Shared definitions for the MMM limb-serial modular subtractor: FSM state
// encoding, default geometry and the limb-counter width helper.
package mmm_defs;

    // Default operand geometry: 260-bit operands handled as four 65-bit limbs.
    localparam int DEF_WIDTH = 260;
    localparam int DEF_LIMB  = 65;

    // Controller states, kept at two bits.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Number of limbs per operand.
    function automatic int nlimb_of(input int width, input int limb);
        return width / limb;
    endfunction

    // Limb counter width, clog2(NLIMB), never narrower than one bit.
    function automatic int cnt_width(input int nlimb);
        return (nlimb > 1) ? $clog2(nlimb) : 1;
    endfunction

endpackage

// File: rtl/mmm_limb_addsub.sv
// Combinational one-limb adder/subtractor shared by the SUB and FIX passes.
// mode=1: {cout, s} = x - y - cin  (cout is the borrow out)
// mode=0: {cout, s} = x + y + cin  (cout is the carry out)
module mmm_limb_addsub #(
    parameter int LIMB = 65
) (
    input  logic [LIMB-1:0] x,
    input  logic [LIMB-1:0] y,
    input  logic            mode,
    input  logic            cin,
    output logic [LIMB-1:0] s,
    output logic            cout
);

    logic [LIMB:0] sum_w;
    logic [LIMB:0] dif_w;

    // Form both the sum and the difference one bit wider and pick one by mode.
    // A negative difference wraps, leaving its top bit set, which is exactly the borrow.
    always_comb begin
        sum_w = {1'b0, x} + {1'b0, y} + {{LIMB{1'b0}}, cin};
        dif_w = {1'b0, x} - {1'b0, y} - {{LIMB{1'b0}}, cin};
        {cout, s} = mode ? dif_w : sum_w;
    end

endmodule

// File: rtl/mmm_mod_sub_limb.sv
// Multi-cycle modular subtractor c = (a - b) mod p, one LIMB-bit limb per cycle.
// A borrow-chained subtract pass is followed, only when the subtraction
// borrowed out of the top limb, by a limb-serial add-back of p.
// Optional feature macro: MMM_MOD_SUB_ZERO_FLAG_EN adds o_zero, set when the
// final result is all zeros.
module mmm_mod_sub_limb
    import mmm_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LIMB  = DEF_LIMB
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_p,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_c,
    output logic             o_flag
`ifdef MMM_MOD_SUB_ZERO_FLAG_EN
    ,
    output logic             o_zero
`endif
);

    localparam int NLIMB = nlimb_of(WIDTH, LIMB);
    localparam int CW    = cnt_width(NLIMB);
    localparam logic [CW-1:0] CNT_LAST = CW'(NLIMB - 1);

    state_e state;
    state_e state_nx;

    // Operands are held in right-shifting registers so the active limb is
    // always at bit 0; the result register shifts each new limb in at the top,
    // so after NLIMB cycles the limbs sit in their natural positions.
    logic [WIDTH-1:0]      a_q;
    logic [WIDTH-1:0]      b_q;
    logic [WIDTH-1:0]      p_q;
    logic [WIDTH-1:0]      c_q;
    logic [WIDTH+LIMB-1:0] c_cat;
    logic [CW-1:0]         cnt;
    logic                  cy;
    logic                  flag_q;
    logic                  last;

    logic [LIMB-1:0] op_x;
    logic [LIMB-1:0] op_y;
    logic [LIMB-1:0] limb_s;
    logic            limb_cout;
    logic            mode;

    assign last  = (cnt == CNT_LAST);
    assign c_cat = {limb_s, c_q};

    // Select the limb operands: a_k - b_k during SUB, d_k + p_k during FIX.
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        mode = 1'b1;
        op_x = a_q[LIMB-1:0];
        op_y = b_q[LIMB-1:0];
        if (state == FIX) begin
            mode = 1'b0;
            op_x = c_q[LIMB-1:0];
            op_y = p_q[LIMB-1:0];
        end
    end

    mmm_limb_addsub #(
        .LIMB (LIMB)
    ) u_addsub (
        .x    (op_x),
        .y    (op_y),
        .mode (mode),
        .cin  (cy),
        .s    (limb_s),
        .cout (limb_cout)
    );

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; a final borrow out of SUB routes through the add-back pass.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (i_start) state_nx = SUB;
            SUB:  if (last)    state_nx = limb_cout ? FIX : DONE;
            FIX:  if (last)    state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: operand capture, limb-serial subtract/add-back, counter and flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_q    <= '0;
            b_q    <= '0;
            p_q    <= '0;
            c_q    <= '0;
            cnt    <= '0;
            cy     <= 1'b0;
            flag_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        a_q <= i_a;
                        b_q <= i_b;
                        p_q <= i_p;
                        cnt <= '0;
                        cy  <= 1'b0;
                    end
                end
                SUB: begin
                    a_q <= a_q >> LIMB;
                    b_q <= b_q >> LIMB;
                    c_q <= c_cat[WIDTH+LIMB-1:LIMB];
                    if (last) begin
                        flag_q <= limb_cout;
                        cnt    <= '0;
                        cy     <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        cy  <= limb_cout;
                    end
                end
                FIX: begin
                    // The carry out of the top limb is dropped: the sum is mod 2^WIDTH.
                    p_q <= p_q >> LIMB;
                    c_q <= c_cat[WIDTH+LIMB-1:LIMB];
                    cy  <= last ? 1'b0 : limb_cout;
                    cnt <= last ? '0 : cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MMM_MOD_SUB_ZERO_FLAG_EN
    logic zero_q;

    // Accumulate the NOR of the result limbs; restarting at limb 0 means a FIX
    // pass overwrites whatever the SUB pass accumulated, so the last pass wins.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            zero_q <= 1'b0;
        end else if (state == SUB || state == FIX) begin
            zero_q <= ((cnt == '0) ? 1'b1 : zero_q) & ~(|limb_s);
        end
    end

    assign o_zero = zero_q;
`endif

    assign o_busy = (state == SUB) || (state == FIX);
    assign o_done = (state == DONE);
    assign o_c    = c_q;
    assign o_flag = flag_q;

endmodule

// File: tb/tb_mmm_mod_sub_limb.sv
// Self-checking bench for mmm_mod_sub_limb: directed corner cases plus
// randomized operands compared against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_mmm_mod_sub_limb;

    localparam int W = 260;
    localparam int L = 65;
    localparam int N = W / L;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_start;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic [W-1:0] i_p;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_c;
    logic         o_flag;
`ifdef MMM_MOD_SUB_ZERO_FLAG_EN
    logic         o_zero;
`endif

    int n_vec = 0;
    int n_err = 0;

    mmm_mod_sub_limb #(
        .WIDTH (W),
        .LIMB  (L)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_p     (i_p),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_c     (o_c),
        .o_flag  (o_flag)
`ifdef MMM_MOD_SUB_ZERO_FLAG_EN
        ,
        .o_zero  (o_zero)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] r = '0;
        for (int i = 0; i < 9; i++) r = (r << 32) | W'($urandom);
        return r;
    endfunction

    // Reference: borrow iff a<b; add p back on borrow; everything mod 2^W.
    function automatic logic model_flag(input logic [W-1:0] a, input logic [W-1:0] b);
        return a < b;
    endfunction

    function automatic logic [W-1:0] model_c(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] p);
        logic [W-1:0] r;
        r = a - b;
        if (a < b) r = r + p;
        return r;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Starts one operation in the current (idle) cycle, checks latency, busy
    // window, result and single-cycle done, and returns in the following idle cycle.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] p);
        logic [W-1:0] exp_c;
        logic         exp_f;
        int           exp_lat;
        int           cyc;
        int           busy_cnt;
        exp_c   = model_c(a, b, p);
        exp_f   = model_flag(a, b);
        exp_lat = exp_f ? 2 * N + 1 : N + 1;
        i_a = a; i_b = b; i_p = p; i_start = 1'b1;
        cyc = 0; busy_cnt = 0;
        do begin
            tick();
            i_start = 1'b0;
            i_a = rand_w(); i_b = rand_w(); i_p = rand_w();
            cyc++;
            if (o_busy) busy_cnt++;
        end while (!o_done && cyc < 40);
        check({tag, "_latency"}, W'(cyc), W'(exp_lat));
        check({tag, "_busy_cycles"}, W'(busy_cnt), W'(exp_lat - 1));
        check({tag, "_c"}, o_c, exp_c);
        check({tag, "_flag"}, W'(o_flag), W'(exp_f));
`ifdef MMM_MOD_SUB_ZERO_FLAG_EN
        check({tag, "_zero"}, W'(o_zero), W'(exp_c == '0));
`endif
        tick();
        check({tag, "_done_pulse"}, W'(o_done), '0);
        check({tag, "_c_held"}, o_c, exp_c);
    endtask

    initial begin
        logic [W-1:0] fa, fb, fp, ra, rb, rp, c5, c6, c11;
        int           done_cnt, d1_cyc, d2_cyc;
        logic         f5;

        i_rst = 1'b1; i_start = 1'b0; i_a = '0; i_b = '0; i_p = '0;
        tick(); tick();
        check("rst_busy", W'(o_busy), '0);
        check("rst_done", W'(o_done), '0);
        check("rst_c", o_c, '0);
        check("rst_flag", W'(o_flag), '0);
        i_rst = 1'b0;
        tick();

        run_op("basic", W'(5), W'(3), W'(7));
        run_op("borrow", W'(3), W'(5), W'(7));

        fa = W'(256'h29c1685372e6fdccaee2c6161d828bbb9f768f903743d3ce2981d290fb3c9d9e);
        fb = W'(256'hd2024aec878e7b574728e44ec83e2ec94fb5dac01879c806fc33a8744458caec);
        fp = W'(1) << 259;
        run_op("fullwidth", fa, fb, fp);

        fa = (W'(1) << 200) + W'(1);
        run_op("equal", fa, fa, fp);
        run_op("limb_borrow", W'(1) << 65, W'(1), fp);
        check("limb_borrow_value", o_c, (W'(1) << 65) - W'(1));

        // Starts in cycles 2 and 5 must be ignored; the one in cycle 6 is accepted.
        i_a = W'(100); i_b = W'(40); i_p = W'(1000); i_start = 1'b1;
        tick();
        done_cnt = 0; d1_cyc = 0; d2_cyc = 0; c5 = '0; c6 = '0; c11 = '0; f5 = 1'b0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            if (o_done) begin
                done_cnt++;
                if (d1_cyc == 0) begin
                    d1_cyc = cyc; c5 = o_c; f5 = o_flag;
                end else begin
                    d2_cyc = cyc; c11 = o_c;
                end
            end
            if (cyc == 6) c6 = o_c;
            i_start = (cyc == 2 || cyc == 5 || cyc == 6);
            if (cyc == 6) begin
                i_a = W'(50); i_b = W'(8); i_p = W'(99);
            end else begin
                i_a = W'(1); i_b = W'(2); i_p = W'(3);
            end
            tick();
        end
        i_start = 1'b0;
        check("busy_start_done_count", W'(done_cnt), W'(2));
        check("busy_start_first_done_cycle", W'(d1_cyc), W'(5));
        check("busy_start_first_c", c5, W'(60));
        check("busy_start_first_flag", W'(f5), '0);
        check("busy_start_c_unchanged", c6, W'(60));
        check("busy_start_second_done_cycle", W'(d2_cyc), W'(11));
        check("busy_start_second_c", c11, W'(42));

        // Reset asserted in cycle 3 of a borrow case.
        i_a = W'(3); i_b = W'(5); i_p = W'(7); i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick(); tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("midrst_busy", W'(o_busy), '0);
        check("midrst_done", W'(o_done), '0);
        check("midrst_c", o_c, '0);
        check("midrst_flag", W'(o_flag), '0);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (o_done) done_cnt++;
            tick();
        end
        check("midrst_no_done", W'(done_cnt), '0);
        run_op("after_rst", W'(3), W'(5), W'(7));

        // Randomized: in-range, arbitrary, equal operands and zero modulus.
        for (int t = 0; t < 30; t++) begin
            case ($urandom_range(0, 3))
                0: begin
                    rp = rand_w();
                    if (rp == '0) rp = W'(1);
                    ra = rand_w() % rp;
                    rb = rand_w() % rp;
                end
                1: begin
                    ra = rand_w(); rb = rand_w(); rp = rand_w();
                end
                2: begin
                    ra = rand_w(); rb = ra; rp = rand_w();
                end
                default: begin
                    ra = rand_w(); rb = rand_w(); rp = '0;
                end
            endcase
            run_op($sformatf("rand%0d", t), ra, rb, rp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mmm_mod_sub_limb.md
Name: mmm_mod_sub_limb

Overview:
Multi-cycle modular subtractor computing c = (a - b) mod p for the MMM datapath. It is the inverse counterpart of the modular adder. Operands are processed one LIMB-bit limb per cycle, with a borrow chain, followed by a conditional limb-serial add-back of p. It sits beside the modular adder in the Montgomery pipeline and trades area for latency on WIDTH-bit operands.

Parameters:
WIDTH, 260, operand/result width in bits
LIMB, 65, limb width per cycle; WIDTH must be an integer multiple of LIMB (NLIMB = WIDTH/LIMB, default 4)

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst  in  1  synchronous reset, active-high
i_start  in  1  start request; sampled only when o_busy=0
i_a  in  WIDTH  minuend; captured on an accepted start
i_b  in  WIDTH  subtrahend; captured on an accepted start
i_p  in  WIDTH  modulus; captured on an accepted start
o_busy  out  1  high from the cycle after an accepted start until o_done is high
o_done  out  1  one-cycle pulse; o_c/o_flag valid in this cycle
o_c  out  WIDTH  result; holds its value until the next accepted start
o_flag  out  1  final borrow of a-b (1 means a<b and p was added back); held like o_c

Behaviour:
- Reset (i_rst=1 at an edge): state IDLE; o_busy=0, o_done=0, o_c=0, o_flag=0; limb counter=0; borrow/carry=0; operand registers=0. Reset is honoured mid-operation and aborts it; no o_done is produced for the aborted operation.
- States: IDLE -> SUB -> (FIX | DONE) -> DONE -> IDLE.
- IDLE: if i_start=1, capture a, b, p; clear the limb counter and borrow; go to SUB.
- SUB, NLIMB cycles: limb k: {bw, d_k} = a_k - b_k - bw, with bw starting at 0. d_k is written into the result register at limb k. The counter increments each cycle.
- At the end of SUB, the final bw becomes o_flag. If bw=1, go to FIX with the counter and carry cleared; otherwise go to DONE.
- FIX, NLIMB cycles: limb k: {cy, r_k} = d_k + p_k + cy. The carry out of the top limb is discarded, so the sum is mod 2^WIDTH. Then go to DONE.
- DONE: o_done=1 for exactly one cycle, then return to IDLE. o_busy=0 in DONE.
- Latency, counted from the edge that samples i_start: o_done is high in cycle NLIMB+1 (no borrow) or 2*NLIMB+1 (borrow). With defaults this is 5 or 9 cycles.
- i_start while busy or in DONE is ignored; there is no queueing.
- Back-to-back: a start in the cycle after DONE (in IDLE) is accepted normally.
- Arithmetic contract: if a<p and b<p, o_c = (a-b) mod p. Otherwise o_c = (a - b + o_flag*p) mod 2^WIDTH. No range checking is performed.
- a==b gives o_c=0 and o_flag=0. p=0 with a<b gives o_c = a-b mod 2^WIDTH.
- Inputs are don't-care outside the start cycle.

Optional Feature:
Macro MMM_MOD_SUB_ZERO_FLAG_EN.
- Defined: adds output o_zero (1 bit, reset 0). o_zero is accumulated as the NOR of all result limbs during the final pass (SUB if no borrow, FIX otherwise). It is valid and held alongside o_c, and is updated at DONE.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared header/package mmm_defs: the state encodings (IDLE, SUB, FIX, DONE as 2-bit localparams), NLIMB derivation, and the counter width clog2(NLIMB).
- Sub-module mmm_limb_addsub: combinational LIMB-bit adder/subtractor with a mode bit, carry/borrow in and carry/borrow out. It is reused for both SUB and FIX.
- The top level holds the FSM, counter, operand/result shift or index registers, and output registers.

Test Plan:
- Basic, WIDTH=260: a=5, b=3, p=7, start at edge 0 -> o_done in cycle 5, o_c=2, o_flag=0; o_busy high in cycles 1-4.
- Borrow: a=3, b=5, p=7 -> o_done in cycle 9, o_c=5, o_flag=1; with MMM_MOD_SUB_ZERO_FLAG_EN, o_zero=0.
- Full-width: a=256'h29c1685372e6fdccaee2c6161d828bbb9f768f903743d3ce2981d290fb3c9d9e, b=256'hd2024aec878e7b574728e44ec83e2ec94fb5dac01879c806fc33a8744458caec, p={1'b1,259'b0} -> o_flag=1, o_c = a - b + 2^259, matching the bench model.
- Equal operands / carry propagation: a=b=2^200+1, p=2^259 -> o_c=0, o_flag=0, o_zero=1 (feature on). Then a=2^65, b=1 -> o_c=2^65-1, verifying the borrow crosses the limb boundary.
- Start while busy: second i_start pulses in cycles 2 and 5 with different operands -> only the first operation completes; exactly one o_done; the result is unchanged by the ignored start. A start in cycle 6 is accepted.
- Reset mid-operation: i_rst=1 in cycle 3 of a borrow case -> next cycle o_busy=0, o_c=0, o_flag=0, no o_done. A new start afterwards completes with the correct result.
